safety_obi_mem_responder: RTL and testbench
===========================================

// Module: safety_obi_mem_responder
// PURPOSE
//  Memory-side responder for the safety core's OBI-style instr/data ports (req/gnt/rvalid).
//  Accepts core requests, range-checks them, forwards in-range accesses to a single-port SRAM bank
//  with fixed read latency and returns in-order responses. Out-of-range accesses get an error response.
//  One instance per core port (instr, data) sits between the core wrapper and its SRAM bank/arbiter.
// PARAMETERS
//  AddrWidth     32            core address width
//  DataWidth     32            data width; byte-enable width is DataWidth/8
//  BaseAddr      32'h0000_0000 first byte address served
//  MemSizeBytes  65536         bytes served; power of two, >= 4
//  SramLatency   1             cycles from SRAM grant to valid sram_rdata_i; legal 1..4
//  ErrCntWidth   16            width of saturating error counter
// PORTS
//  clk_i         in   1          clock
//  rst_ni        in   1          asynchronous active-low reset
//  req_i         in   1          core request valid
//  gnt_o         out  1          request accepted this cycle
//  we_i          in   1          1 = write
//  be_i          in   DW/8       byte enables
//  addr_i        in   AW         byte address
//  wdata_i       in   DW         write data
//  rvalid_o      out  1          response valid (no back-pressure; core always accepts)
//  rdata_o       out  DW         read data
//  err_o         out  1          response error, qualified by rvalid_o
//  sram_req_o    out  1          SRAM access request
//  sram_gnt_i    in   1          SRAM/arbiter grant (combinational accept)
//  sram_we_o     out  1          SRAM write enable
//  sram_be_o     out  DW/8       SRAM byte enables
//  sram_addr_o   out  log2(MemSizeBytes)-2  SRAM word index
//  sram_wdata_o  out  DW         SRAM write data
//  sram_rdata_i  in   DW         SRAM read data, valid SramLatency cycles after granted access
//  err_cnt_o     out  ErrCntWidth  number of errored accesses, saturating
// BEHAVIOUR
//  - Reset: gnt_o=0 (reset holds outputs low), rvalid_o=0, err_o=0, rdata_o=0, sram_req_o=0, err_cnt_o=0;
//    response pipeline cleared. Reset mid-operation drops all outstanding responses; none emitted after.
//  - In range: BaseAddr <= addr_i < BaseAddr+MemSizeBytes (compare in AW+1 bits, no wrap).
//  - In-range: sram_req_o=req_i; sram_we/be/wdata pass through; sram_addr_o=(addr_i-BaseAddr)>>2;
//    gnt_o=req_i&&sram_gnt_i (combinational). Request held by core until granted.
//  - Out-of-range: sram_req_o=0, gnt_o=req_i (granted same cycle); no SRAM write ever occurs.
//  - Grant cycle T pushes {valid,err,we} into a SramLatency-deep shift pipeline;
//    rvalid_o=1 exactly at cycle T+SramLatency, one response per grant, strictly in grant order.
//  - Back-to-back grants every cycle supported: throughput 1 access/cycle, no bubbles.
//  - rdata_o = sram_rdata_i for in-range reads; 0 for writes and errored accesses.
//  - err_o=1 only with rvalid_o for out-of-range access; err_o=0 otherwise.
//  - err_cnt_o increments by 1 at each errored response (rvalid_o&&err_o); holds at all-ones.
//  - No internal state other than pipeline and counter; no FSM beyond the shift register.
//  - sram_gnt_i low with req_i high: gnt_o=0, nothing pushed, core stalls, request lines unchanged.
// TESTING
//  - Write 0xDEADBEEF be=4'hF @BaseAddr+0x10, then read -> read rvalid at T+SramLatency, rdata 0xDEADBEEF, err 0.
//  - Byte write be=4'b0010 data 0x0000AB00 over 0xDEADBEEF, read -> 0xDEADABEF.
//  - Read @BaseAddr+MemSizeBytes -> gnt same cycle, sram_req_o never 1, rvalid+err at T+Lat, rdata 0, err_cnt 1.
//  - sram_gnt_i low 3 cycles during req -> gnt_o 0 for 3 cycles, single response after eventual grant.
//  - SramLatency=3, 8 back-to-back reads of distinct addresses -> 8 consecutive rvalids, in order.
//  - Assert rst_ni low with 2 responses in flight -> no rvalid after release; ErrCntWidth=2, 5 errors -> err_cnt_o 3.

Source files
------------

// File: rtl/safety_obi_mem_responder.sv
// OBI-style req/gnt/rvalid responder in front of one single-port SRAM bank.
// Range-checks requests, forwards in-range ones, returns in-order responses.
//
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   req_i/gnt_o/we_i/be_i/addr_i/wdata_i   core request channel
//   rvalid_o/rdata_o/err_o         core response channel (no back-pressure)
//   sram_req_o/sram_gnt_i/sram_we_o/sram_be_o/sram_addr_o/sram_wdata_o
//                                  SRAM access channel
//   sram_rdata_i                   SRAM read data, SramLatency after grant
//   err_cnt_o                      saturating count of errored responses
module safety_obi_mem_responder #(
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned DataWidth    = 32,
  parameter logic [AddrWidth-1:0] BaseAddr = '0,
  parameter int unsigned MemSizeBytes = 65536,
  parameter int unsigned SramLatency  = 1,
  parameter int unsigned ErrCntWidth  = 16,
  localparam int unsigned BeWidth = DataWidth / 8,
  localparam int unsigned MemAw   = $clog2(MemSizeBytes),
  localparam int unsigned SramAw  = (MemAw > 2) ? MemAw - 2 : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,

  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic                   we_i,
  input  logic [BeWidth-1:0]     be_i,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic [DataWidth-1:0]   wdata_i,

  output logic                   rvalid_o,
  output logic [DataWidth-1:0]   rdata_o,
  output logic                   err_o,

  output logic                   sram_req_o,
  input  logic                   sram_gnt_i,
  output logic                   sram_we_o,
  output logic [BeWidth-1:0]     sram_be_o,
  output logic [SramAw-1:0]      sram_addr_o,
  output logic [DataWidth-1:0]   sram_wdata_o,
  input  logic [DataWidth-1:0]   sram_rdata_i,

  output logic [ErrCntWidth-1:0] err_cnt_o
);

  localparam int unsigned Aw1 = AddrWidth + 1;

  typedef struct packed {
    logic valid;
    logic err;
    logic we;
  } slot_t;

  logic [AddrWidth:0]   addr_x;
  logic [AddrWidth:0]   lo_x;
  logic [AddrWidth:0]   hi_x;
  logic                 in_range;
  logic [AddrWidth-1:0] offset;
  logic                 unused_offset;

  slot_t                pipe_q [SramLatency];
  slot_t                push;
  slot_t                head;

  logic [ErrCntWidth-1:0] err_cnt_q;

  // One extra bit so BaseAddr+MemSizeBytes never wraps.
  assign addr_x   = {1'b0, addr_i};
  assign lo_x     = {1'b0, BaseAddr};
  assign hi_x     = lo_x + Aw1'(MemSizeBytes);
  assign in_range = (addr_x >= lo_x) && (addr_x < hi_x);

  assign offset        = addr_i - BaseAddr;
  assign unused_offset = ^{offset[AddrWidth-1:SramAw+2],
                           offset[1:0]};

  // Held low while reset is asserted.
  assign sram_req_o   = rst_ni & req_i & in_range;
  assign sram_we_o    = we_i;
  assign sram_be_o    = be_i;
  assign sram_wdata_o = wdata_i;
  assign sram_addr_o  = offset[SramAw+1:2];

  // Out-of-range requests never touch SRAM and are accepted at once.
  assign gnt_o = rst_ni & req_i
               & (in_range ? sram_gnt_i : 1'b1);

  always_comb begin
    push       = '0;
    push.valid = gnt_o;
    push.err   = gnt_o & ~in_range;
    push.we    = gnt_o & we_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SramLatency; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= push;
      for (int i = 1; i < SramLatency; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign head = pipe_q[SramLatency-1];

  assign rvalid_o = head.valid;
  assign err_o    = head.valid & head.err;
  assign rdata_o  = (head.valid && !head.err && !head.we)
                  ? sram_rdata_i : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else if (rvalid_o && err_o && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_safety_obi_mem_responder.sv
// Bench for safety_obi_mem_responder: two instances (latency 1 and 3)
// share one request stream and are checked against a scoreboard model.
module tb_safety_obi_mem_responder;

  localparam logic [31:0] BASE = 32'h0000_4000;
  localparam int unsigned SIZE = 1024;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic req, we, sgnt;
  logic [3:0]  be;
  logic [31:0] addr, wdata;

  logic [1:0] gnt, rvalid, err, sreq, swe;
  logic [1:0][31:0] rdata, swdata, srdata;
  logic [1:0][3:0]  sbe;
  logic [1:0][7:0]  saddr;
  logic [15:0] ecnt_a;
  logic [1:0]  ecnt_b;

  always #5 clk = ~clk;

  safety_obi_mem_responder #(
    .BaseAddr(BASE), .MemSizeBytes(SIZE),
    .SramLatency(LAT_A), .ErrCntWidth(16)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req), .gnt_o(gnt[0]), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata),
    .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]),
    .sram_req_o(sreq[0]), .sram_gnt_i(sgnt), .sram_we_o(swe[0]),
    .sram_be_o(sbe[0]), .sram_addr_o(saddr[0]),
    .sram_wdata_o(swdata[0]), .sram_rdata_i(srdata[0]),
    .err_cnt_o(ecnt_a)
  );

  safety_obi_mem_responder #(
    .BaseAddr(BASE), .MemSizeBytes(SIZE),
    .SramLatency(LAT_B), .ErrCntWidth(2)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req), .gnt_o(gnt[1]), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata),
    .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]),
    .sram_req_o(sreq[1]), .sram_gnt_i(sgnt), .sram_we_o(swe[1]),
    .sram_be_o(sbe[1]), .sram_addr_o(saddr[1]),
    .sram_wdata_o(swdata[1]), .sram_rdata_i(srdata[1]),
    .err_cnt_o(ecnt_b)
  );

  // SRAM bank models with fixed read latency.
  for (genvar k = 0; k < 2; k++) begin : g_sram
    localparam int LAT = (k == 0) ? LAT_A : LAT_B;
    logic [31:0] mem  [256];
    logic [31:0] pipe [LAT];
    initial for (int i = 0; i < 256; i++) mem[i] = '0;
    always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= 32'hA5A5_A5A5;
      if (sreq[k] && sgnt) begin
        if (swe[k]) begin
          for (int b = 0; b < 4; b++)
            if (sbe[k][b])
              mem[saddr[k]][8*b +: 8] <= swdata[k][8*b +: 8];
        end else begin
          pipe[0] <= mem[saddr[k]];
        end
      end
    end
    assign srdata[k] = pipe[LAT-1];
  end

  // Reference model: expected responses in grant order.
  typedef struct {
    int          t;
    bit          err;
    logic [31:0] data;
  } rsp_t;

  rsp_t        q[$];
  int          head [2];
  int          lat  [2];
  logic [15:0] cnt_exp [2];
  logic [15:0] cnt_max [2];
  logic [31:0] ref_mem [256];
  int          cyc;
  int          n_chk;
  int          n_fail;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ecnt(input int k);
    return (k == 0) ? ecnt_a : {14'b0, ecnt_b};
  endfunction

  task automatic check_rsp(input int k);
    bit due;
    chk($sformatf("err_cnt%0d", k), 64'(ecnt(k)), 64'(cnt_exp[k]));
    due = (head[k] < q.size()) && (q[head[k]].t + lat[k] == cyc);
    chk($sformatf("rvalid%0d", k), 64'(rvalid[k]), 64'(due));
    if (due) begin
      chk($sformatf("err%0d", k), 64'(err[k]),
          64'(q[head[k]].err));
      chk($sformatf("rdata%0d", k), 64'(rdata[k]),
          64'(q[head[k]].data));
      if (q[head[k]].err && cnt_exp[k] != cnt_max[k])
        cnt_exp[k]++;
      head[k]++;
    end else begin
      chk($sformatf("err_idle%0d", k), 64'(err[k]), 64'(0));
    end
  endtask

  task automatic step(input logic r, input logic w,
                      input logic [3:0] b,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic g,
                      output bit granted);
    bit inr;
    int idx;
    longint la;
    req = r; we = w; be = b; addr = a; wdata = d; sgnt = g;
    la  = longint'(a);
    inr = (la >= longint'(BASE)) &&
          (la < longint'(BASE) + longint'(SIZE));
    idx = inr ? int'((a - BASE) >> 2) : 0;
    granted = r && (!inr || g);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("gnt%0d", k), 64'(gnt[k]), 64'(granted));
      chk($sformatf("sram_req%0d", k), 64'(sreq[k]),
          64'(r && inr));
      if (r && inr) begin
        chk($sformatf("sram_addr%0d", k), 64'(saddr[k]),
            64'(idx));
        chk($sformatf("sram_we%0d", k), 64'(swe[k]), 64'(w));
        chk($sformatf("sram_be%0d", k), 64'(sbe[k]), 64'(b));
        chk($sformatf("sram_wd%0d", k), 64'(swdata[k]), 64'(d));
      end
      check_rsp(k);
    end
    @(posedge clk);
    if (granted) begin
      rsp_t e;
      e.t    = cyc;
      e.err  = !inr;
      e.data = (inr && !w) ? ref_mem[idx] : 32'h0;
      q.push_back(e);
      if (inr && w)
        for (int i = 0; i < 4; i++)
          if (b[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit gd;
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, gd);
  endtask

  task automatic reset_check();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_gnt%0d", k), 64'(gnt[k]), 64'(0));
      chk($sformatf("rst_sreq%0d", k), 64'(sreq[k]), 64'(0));
      chk($sformatf("rst_rvalid%0d", k), 64'(rvalid[k]), 64'(0));
      chk($sformatf("rst_err%0d", k), 64'(err[k]), 64'(0));
      chk($sformatf("rst_rdata%0d", k), 64'(rdata[k]), 64'(0));
      chk($sformatf("rst_ecnt%0d", k), 64'(ecnt(k)), 64'(0));
    end
  endtask

  initial begin
    bit gd;
    bit held;
    logic r, w, g;
    logic [3:0]  b;
    logic [31:0] a, d;
    int cat;

    n_chk = 0; n_fail = 0; cyc = 0;
    lat[0] = LAT_A; lat[1] = LAT_B;
    cnt_max[0] = 16'hFFFF; cnt_max[1] = 16'h0003;
    for (int k = 0; k < 2; k++) begin
      head[k] = 0; cnt_exp[k] = '0;
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;

    rst_n = 1'b0;
    req = 1'b1; we = 1'b0; be = 4'hF;
    addr = BASE; wdata = '0; sgnt = 1'b1;
    @(negedge clk);
    #1 reset_check();
    @(negedge clk);
    rst_n = 1'b1;

    // Full word write then read back.
    step(1'b1, 1'b1, 4'hF, BASE + 32'h10, 32'hDEADBEEF, 1'b1, gd);
    step(1'b1, 1'b0, 4'hF, BASE + 32'h10, 32'h0, 1'b1, gd);
    idle(4);
    // Single byte lane write then read back.
    step(1'b1, 1'b1, 4'b0010, BASE + 32'h10, 32'h0000AB00, 1'b1, gd);
    step(1'b1, 1'b0, 4'hF, BASE + 32'h10, 32'h0, 1'b1, gd);
    idle(4);
    // First address past the window, last in, just below.
    step(1'b1, 1'b0, 4'hF, BASE + SIZE, 32'h0, 1'b1, gd);
    step(1'b1, 1'b1, 4'hF, BASE + SIZE - 4, 32'h1234_5678, 1'b0, gd);
    step(1'b1, 1'b1, 4'hF, BASE + SIZE - 4, 32'h1234_5678, 1'b1, gd);
    step(1'b1, 1'b0, 4'hF, BASE - 4, 32'h0, 1'b1, gd);
    step(1'b1, 1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0, 1'b1, gd);
    step(1'b1, 1'b0, 4'hF, BASE + SIZE - 4, 32'h0, 1'b1, gd);
    idle(4);
    // SRAM grant withheld for three cycles.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 4'hF, BASE + 32'h10, 32'h0, 1'b0, gd);
    step(1'b1, 1'b0, 4'hF, BASE + 32'h10, 32'h0, 1'b1, gd);
    idle(5);
    // Fill eight words, then eight back-to-back reads.
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, 4'hF, BASE + 32'(4 * (i + 32)),
           32'hC0DE_0000 + 32'(i), 1'b1, gd);
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b0, 4'hF, BASE + 32'(4 * (i + 32)),
           32'h0, 1'b1, gd);
    idle(5);

    // Randomized traffic; a stalled request is held until granted.
    held = 1'b0;
    r = 0; w = 0; b = 0; a = 0; d = 0;
    for (int n = 0; n < 400; n++) begin
      if (!held) begin
        r = ($urandom_range(0, 9) < 8);
        w = $urandom_range(0, 1);
        b = 4'($urandom_range(1, 15));
        d = $urandom;
        cat = $urandom_range(0, 9);
        if (cat < 7)
          a = BASE + 32'($urandom_range(0, SIZE - 1));
        else if (cat == 7)
          a = BASE - 32'($urandom_range(1, 32'h4000));
        else if (cat == 8)
          a = BASE + SIZE + 32'($urandom_range(0, 4095));
        else
          a = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
      end
      g = ($urandom_range(0, 9) < 7);
      step(r, w, b, a, d, g, gd);
      held = r && !gd;
    end
    idle(5);

    // Reset with two reads in flight drops both responses.
    step(1'b1, 1'b0, 4'hF, BASE + 32'h20, 32'h0, 1'b1, gd);
    step(1'b1, 1'b0, 4'hF, BASE + 32'h24, 32'h0, 1'b1, gd);
    rst_n = 1'b0;
    req = 1'b1; addr = BASE + 32'h28; sgnt = 1'b1;
    #1 reset_check();
    @(posedge clk); cyc++;
    @(negedge clk);
    #1 reset_check();
    @(posedge clk); cyc++;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      head[k] = q.size(); cnt_exp[k] = '0;
    end
    rst_n = 1'b1;
    idle(6);

    // Five errors: narrow counter saturates at 3.
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, 4'hF, BASE + SIZE + 32'(4 * i),
           32'h0, 1'b1, gd);
    idle(5);
    chk("ecnt_a_five", 64'(ecnt_a), 64'(5));
    chk("ecnt_b_sat", 64'(ecnt_b), 64'(3));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
